// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder with a 2-entry output FIFO and sequential IMEM word addressing.
// Optional IMM_RANGE_CHECK_EN adds immediate-fit checking to the error flag.
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [31:0]       enc_instr;
    logic              enc_err;
    logic [31:0]       mem_instr [2];
    logic              mem_err   [2];
    logic              wptr, rptr;
    logic [1:0]        cnt, cnt_n;
    logic              in_ready_r;
    logic [ADDR_W-1:0] addr;
    logic              push, pop;

    always_comb begin
        enc_instr = 32'h0000_0013;
        enc_err   = 1'b0;
        case (fmt)
            3'd0: enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1: begin
                enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
                enc_err = !((&imm[31:11]) || !(|imm[31:11]));
`endif
            end
            3'd2: begin
                enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef IMM_RANGE_CHECK_EN
                enc_err = !((&imm[31:11]) || !(|imm[31:11]));
`endif
            end
            3'd3: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err   = imm[0];
`ifdef IMM_RANGE_CHECK_EN
                enc_err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
`endif
            end
            3'd4: begin
                enc_instr = {imm[31:12], rd, opcode};
`ifdef IMM_RANGE_CHECK_EN
                enc_err = |imm[11:0];
`endif
            end
            3'd5: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err   = imm[0];
`ifdef IMM_RANGE_CHECK_EN
                enc_err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
`endif
            end
            default: begin
                enc_instr = 32'h0000_0013;
                enc_err   = 1'b1;
            end
        endcase
    end

    assign in_ready  = in_ready_r;
    assign out_valid = (cnt != 2'd0);
    assign push      = in_valid && in_ready_r;
    assign pop       = out_valid && out_ready;

    // Empty FIFO presents zeros so the idle output matches the reset state.
    assign out_instr = out_valid ? mem_instr[rptr] : 32'h0;
    assign out_err   = out_valid ? mem_err[rptr] : 1'b0;
    assign out_addr  = addr;

    always_comb begin
        cnt_n = cnt;
        if (push && !pop)
            cnt_n = cnt + 2'd1;
        else if (!push && pop)
            cnt_n = cnt - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wptr] <= enc_instr;
            mem_err[wptr]   <= enc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            cnt        <= 2'd0;
            in_ready_r <= 1'b1;
            addr       <= BASE;
        end else begin
            if (push)
                wptr <= ~wptr;
            if (pop)
                rptr <= ~rptr;
            cnt        <= cnt_n;
            in_ready_r <= (cnt_n != 2'd2);
            // clr overrides the post-transfer increment; the word leaving now keeps its address.
            if (clr)
                addr <= BASE;
            else if (pop)
                addr <= addr + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: packing per format, errors, backpressure, wrap, clr, reset.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]  fmt, funct3;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, out_instr;
    logic [1:0]  out_addr;
    logic        exp_rng_err;

    int total = 0;
    int bad   = 0;

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic setb(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = 7'h0; imm = im;
    endtask

    // Offer one bundle for one edge (encoder is assumed ready), then withdraw it.
    task automatic send();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        setb(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0);
`ifdef IMM_RANGE_CHECK_EN
        exp_rng_err = 1'b1;
`else
        exp_rng_err = 1'b0;
`endif
        tick(); tick();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_addr", {30'b0, out_addr}, 32'd0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_err", {31'b0, out_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // I, S, B, J, U back to back; the fifth word wraps the 2-bit address
        setb(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5); send();
        chk("i_valid", {31'b0, out_valid}, 32'd1);
        chk("i_instr", out_instr, 32'h0050_0093);
        chk("i_err", {31'b0, out_err}, 32'd0);
        chk("i_addr", {30'b0, out_addr}, 32'd0);
        tick();
        chk("i_drained", {31'b0, out_valid}, 32'd0);

        setb(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8); send();
        chk("s_instr", out_instr, 32'h0020_A423);
        chk("s_addr", {30'b0, out_addr}, 32'd1);
        tick();

        setb(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC); send();
        chk("b_instr", out_instr, 32'hFE00_0EE3);
        chk("b_err", {31'b0, out_err}, 32'd0);
        chk("b_addr", {30'b0, out_addr}, 32'd2);
        tick();

        setb(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800); send();
        chk("j_instr", out_instr, 32'h0010_00EF);
        chk("j_addr", {30'b0, out_addr}, 32'd3);
        tick();

        setb(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000); send();
        chk("u_instr", out_instr, 32'h1234_52B7);
        chk("u_err", {31'b0, out_err}, 32'd0);
        chk("u_addr_wrap", {30'b0, out_addr}, 32'd0);
        tick();

        // error cases
        setb(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 32'h0); send();
        chk("ill_instr", out_instr, 32'h0000_0013);
        chk("ill_err", {31'b0, out_err}, 32'd1);
        tick();

        setb(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3); send();
        chk("bmis_instr", out_instr, 32'h0000_0163);
        chk("bmis_err", {31'b0, out_err}, 32'd1);
        tick();

        setb(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048); send();
        chk("irng_instr", out_instr, 32'h8000_0093);
        chk("irng_err", {31'b0, out_err}, {31'b0, exp_rng_err});
        tick();

        // clr alone, then clr coincident with the transfer at address 1
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_addr", {30'b0, out_addr}, 32'd0);
        setb(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1); send();
        tick();
        setb(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2); send();
        chk("clrx_addr", {30'b0, out_addr}, 32'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        setb(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3); send();
        chk("clrx_next_addr", {30'b0, out_addr}, 32'd0);
        chk("clrx_next_instr", out_instr, 32'h0030_0093);
        tick();
        clr = 1'b1; tick(); clr = 1'b0;

        // backpressure: three bundles offered, two buffered, in_ready drops
        out_ready = 1'b0;
        in_valid  = 1'b1;
        setb(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1); tick();
        chk("bp_ready1", {31'b0, in_ready}, 32'd1);
        setb(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2); tick();
        chk("bp_full", {31'b0, in_ready}, 32'd0);
        setb(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3); tick();
        chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_instr", out_instr, 32'h0010_0093);
        chk("bp_hold_addr", {30'b0, out_addr}, 32'd0);
        out_ready = 1'b1; tick();
        chk("bp_w1_instr", out_instr, 32'h0020_0093);
        chk("bp_w1_addr", {30'b0, out_addr}, 32'd1);
        chk("bp_w1_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_w2_instr", out_instr, 32'h0030_0093);
        chk("bp_w2_addr", {30'b0, out_addr}, 32'd2);
        tick();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // reset with two words buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        chk("mid_full", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("mid_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_addr", {30'b0, out_addr}, 32'd0);
        tick();
        chk("mid_still_empty", {31'b0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
